// File: rtl/hm74_pkg.sv
// hm74_pkg: shared codeword layout, types and helpers for the HM74 link.
package hm74_pkg;
    localparam int P0 = 6;
    localparam int P1 = 5;
    localparam int D3 = 4;
    localparam int P2 = 3;
    localparam int D2 = 2;
    localparam int D1 = 1;
    localparam int D0 = 0;

    typedef logic [2:0] syndrome_t;
    typedef logic [6:0] codeword_t;

    // A non-zero syndrome names the erroneous bit counted from the MSB.
    function automatic logic [2:0] syn_to_pos(input syndrome_t s);
        return 3'd7 - s;
    endfunction
endpackage

// File: rtl/hm74_syndrome.sv
// hm74_syndrome: combinational Hamming(7,4) syndrome of a codeword.
module hm74_syndrome
    import hm74_pkg::*;
(
    input  logic [6:0] word,
    output logic [2:0] syn
);
    assign syn = {word[P2] ^ word[D2] ^ word[D1] ^ word[D0],
                  word[P1] ^ word[D3] ^ word[D1] ^ word[D0],
                  word[P0] ^ word[D3] ^ word[D2] ^ word[D0]};
endmodule

// File: rtl/hm74_decoder.sv
// hm74_decoder: two-stage streaming Hamming(7,4) decoder with backpressure.
module hm74_decoder
  import hm74_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ham_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] data_out,
  output logic [2:0] syndrome,
  output logic       corrected,
  output logic       out_valid,
  input  logic       out_ready
`ifdef HM74_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  logic      s1_valid, s2_valid, adv1, adv2;
  codeword_t s1_word, fixed;
  syndrome_t s1_syn, in_syn;
  hm74_syndrome u_syn (.word(ham_in), .syn(in_syn));
  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  always_comb fixed = s1_word ^ ((s1_syn != '0) ? codeword_t'(7'd1 << syn_to_pos(s1_syn)) : '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= ham_in;
        s1_syn  <= in_syn;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      data_out  <= '0;
      syndrome  <= '0;
      corrected <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out  <= {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
        syndrome  <= s1_syn;
        corrected <= s1_syn != '0;
      end
    end
  end
`ifdef HM74_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (s2_valid && out_ready && corrected && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_hm74_decoder.sv
// tb_hm74_decoder: randomized and directed checks against a nearest-codeword reference model.
module tb_hm74_decoder;
  localparam int CNT_W = 4;
`ifdef HM74_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, corrected;
  logic [6:0] ham_in;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic       c;
    int         acc;
  } ent_t;
  ent_t q[$];
  int cyc = 0, err_exp = 0, compared = 0, mismatched = 0;
  logic last_acc;
  logic [6:0] burst [5];

  hm74_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ham_in(ham_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .syndrome(syndrome), .corrected(corrected),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef HM74_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3], d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
  endfunction

  function automatic ent_t ref_decode(input logic [6:0] cw);
    ent_t r;
    logic [6:0] diff;
    r = '{d: 4'd0, s: 3'd0, c: 1'b0, acc: 0};
    for (int d = 0; d < 16; d++) begin
      diff = cw ^ encode(4'(d));
      if (diff == 7'd0) r = '{d: 4'(d), s: 3'd0, c: 1'b0, acc: 0};
      else if ($countones(diff) == 1)
        for (int b = 0; b < 7; b++)
          if (diff[b]) r = '{d: 4'(d), s: 3'(7 - b), c: 1'b1, acc: 0};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic exp_rdy, exp_ov, acc, del;
    ent_t e;
    @(negedge clk);
    exp_rdy = (q.size() < 2) || out_ready;
    exp_ov  = (q.size() > 0) && (q[0].acc < cyc);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("data_out", data_out, q[0].d);
      chk("syndrome", syndrome, q[0].s);
      chk("corrected", corrected, q[0].c);
    end
`ifdef HM74_ERR_CNT_EN
    chk("err_cnt", err_cnt, err_exp);
`endif
    acc = in_valid && exp_rdy;
    del = exp_ov && out_ready;
    e   = ref_decode(ham_in);
    @(posedge clk);
    cyc++;
    if (del) begin
`ifdef HM74_ERR_CNT_EN
      if (q[0].c && err_exp < (1 << CNT_W) - 1) err_exp++;
`endif
      void'(q.pop_front());
    end
    if (acc) begin
      e.acc = cyc;
      q.push_back(e);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [6:0] w, input logic rdy);
    ham_in = w;
    in_valid = 1'b1;
    out_ready = rdy;
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ham_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_syndrome", syndrome, 0);
    chk("rst_corrected", corrected, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef HM74_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    #1 rst = 1'b0;
    send(7'b0100101, 1'b1);
    send(7'b0100001, 1'b1);
    drain();
    for (int d = 0; d < 16; d++)
      for (int b = 0; b < 7; b++)
        send(encode(4'(d)) ^ 7'(1 << b), 1'b1);
    drain();
    for (int i = 0; i < 5; i++) burst[i] = 7'($urandom);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      send(burst[n], 1'b0);
      if (last_acc) n++;
    end
    chk("stall_accepts", n, 2);
    for (int i = 0; i < 20 && n < 5; i++) begin
      send(burst[n], 1'b1);
      if (last_acc) n++;
    end
    chk("burst_accepts", n, 5);
    drain();
    for (int i = 0; i < 400; i++) begin
      ham_in = 7'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();
    send(encode(4'd9) ^ 7'd8, 1'b0);
    send(encode(4'd3) ^ 7'd1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef HM74_ERR_CNT_EN
    chk("midrst_err_cnt", err_cnt, 0);
`endif
    q.delete();
    err_exp = 0;
    #1 rst = 1'b0;
    send(encode(4'd12) ^ 7'd64, 1'b1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
